debounce_scan_ctrl: RTL and testbench
=====================================

Name: debounce_scan_ctrl

Overview:
Time-multiplexed debounce controller for a bank of noisy inputs (buttons, switches). It uses one shared evaluation datapath: a round-robin scheduler visits one channel per prescaler tick, tracks consecutive disagreeing samples per channel, and flips that channel's clean level after STABLE_CNT agreeing samples. Each flip is posted as an event on a valid/ready interface to the downstream interrupt and status logic.

Parameters:
N_CH, 8, number of input channels (2..32)
TICK_DIV, 1000, clk cycles per scheduler tick (>=4)
STABLE_CNT, 4, consecutive differing samples required to flip a channel (2..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = prescaler and scheduler run; 0 = freeze (state held)
raw_in  input  N_CH  asynchronous noisy inputs
clean_out  output  N_CH  debounced levels
evt_valid  output  1  event pending
evt_ready  input  1  consumer accepts event
evt_ch  output  clog2(N_CH)  channel index of event
evt_level  output  1  new clean level of that channel
missed_tick  output  1  sticky: a tick arrived while FSM not IDLE

Behaviour:
- Reset (rst_n=0, async): sync regs, clean_out, all per-channel counters, prescaler, ptr = 0; evt_valid=0, evt_ch=0, evt_level=0, missed_tick=0; FSM=IDLE. Deassertion is synchronous to clk and handled externally.
- raw_in passes through a 2-FF synchronizer per bit. The scheduler reads the synchronized value only.
- Prescaler: counts 0..TICK_DIV-1 while enable=1. tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0. When enable=0, count holds and no tick is generated.
- Per-channel counter cnt[i] is clog2(STABLE_CNT+1) bits.
- FSM states:
  - IDLE: on tick -> EVAL.
  - EVAL (1 cycle), s = sync[ptr]:
    - if s==clean_out[ptr]: cnt[ptr]<=0; ptr advances; -> IDLE.
    - else if cnt[ptr]+1 < STABLE_CNT: cnt[ptr]++; ptr advances; -> IDLE.
    - else (flip due): if the event slot is free (evt_valid=0, or evt_valid=1 with evt_ready=1 in the same cycle), commit the flip; else -> HOLD with ptr unchanged.
  - Commit: clean_out[ptr]<=s, cnt[ptr]<=0, evt_valid<=1, evt_ch<=ptr, evt_level<=s, ptr advances, -> IDLE.
  - HOLD: each cycle, when the slot frees (evt_ready=1 while evt_valid=1), commit the pending flip in that cycle, then -> IDLE. No other channel is evaluated while in HOLD.
- ptr advance: ptr==N_CH-1 -> 0, else ptr+1.
- Latency: a clean input change is reflected on clean_out no earlier than 2 sync cycles + (STABLE_CNT-1)*N_CH*TICK_DIV + 1 cycles after it settles.
- Event interface:
  - evt_ch and evt_level are stable while evt_valid=1 and evt_ready=0.
  - A transfer occurs on any cycle with evt_valid&evt_ready.
  - evt_valid drops the cycle after the transfer unless a commit happens in the same cycle (back-to-back events allowed).
- missed_tick: set when tick=1 and FSM!=IDLE; cleared only by reset. The missed tick is discarded, not queued.
- enable=0 mid-operation: EVAL and HOLD complete normally, and the event interface stays live. Only new ticks stop.
- A flip does not alter other channels' counters. A glitch (one agreeing sample) resets that channel's cnt to 0.

Test Plan:
1. Reset mid-HOLD: N_CH=4, TICK_DIV=4, STABLE_CNT=3; all raw_in=0 -> clean_out=0, evt_valid=0 for 200 cycles. Assert rst_n=0 mid-HOLD -> all outputs 0 immediately (async).
2. Single clean flip: raw_in[2] 0->1 held, evt_ready=1 -> clean_out[2]=1 after ~3 visits (~48 cycles ±16). Exactly one event {ch=2, level=1}, evt_valid high 1 cycle.
3. Glitch rejection: raw_in[1] high for 2 visits, low 1 visit, high 2 visits -> no event and clean_out[1]=0. A 3rd consecutive high visit -> event {ch=1, level=1}.
4. Backpressure: evt_ready=0; raw_in[0] and raw_in[3] both go 1 -> first event {0,1} held stable; FSM in HOLD at ch 3; missed_tick=1 after a further tick. Raise evt_ready -> {3,1} follows back-to-back with no bubble.
5. Wrap and freeze: verify ptr order 0,1,2,3,0 via flip ordering. Drop enable for 50 cycles -> clean_out/cnt unchanged and no events; re-enable -> resumes at the same ptr.

Source files
------------

// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl: time-multiplexed debouncer for a bank of noisy inputs.
//
// A prescaler produces one scheduler tick every TICK_DIV cycles. On each tick,
// one channel (round-robin) is evaluated by a single shared datapath. A channel
// whose synchronized input has disagreed with its clean level for STABLE_CNT
// consecutive visits flips its clean level. Each flip is posted as an event on
// a valid/ready interface.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      1 = prescaler/scheduler run, 0 = no new ticks (state held)
//   raw_in      asynchronous noisy inputs, one bit per channel
//   clean_out   debounced levels
//   evt_valid   event pending
//   evt_ready   consumer accepts event
//   evt_ch      channel index of the pending event
//   evt_level   new clean level of that channel
//   missed_tick sticky flag: a tick arrived while the FSM was busy
module debounce_scan_ctrl #(
  parameter int unsigned N_CH       = 8,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [N_CH-1:0]          raw_in,
  output logic [N_CH-1:0]          clean_out,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_CH)-1:0]  evt_ch,
  output logic                     evt_level,
  output logic                     missed_tick
);

  localparam int unsigned PtrW = $clog2(N_CH);
  localparam int unsigned CntW = $clog2(STABLE_CNT + 1);
  localparam int unsigned PreW = $clog2(TICK_DIV);

  localparam logic [PreW-1:0] PreMax  = PreW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CNT - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(N_CH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StHold
  } state_e;

  state_e state_q, state_d;

  // Two-stage synchronizer, one per channel.
  logic [N_CH-1:0] sync1_q, sync2_q;

  logic [PreW-1:0] pre_q;
  logic            tick;

  logic [PtrW-1:0] ptr_q;
  logic [CntW-1:0] cnt_q [N_CH];
  logic [N_CH-1:0] clean_q;

  logic            evt_valid_q;
  logic [PtrW-1:0] evt_ch_q;
  logic            evt_level_q;
  logic            missed_q;

  // Shared evaluation datapath, looking at the channel under the pointer.
  logic            cur_sync;
  logic            cur_clean;
  logic [CntW-1:0] cur_cnt;
  logic            slot_free;
  logic            xfer;

  // FSM outputs.
  logic            commit;
  logic            cnt_we;
  logic [CntW-1:0] cnt_wdata;
  logic            ptr_adv;

  assign cur_sync  = sync2_q[ptr_q];
  assign cur_clean = clean_q[ptr_q];
  assign cur_cnt   = cnt_q[ptr_q];
  assign xfer      = evt_valid_q & evt_ready;
  // The slot can take a new event if empty, or if it empties this same cycle.
  assign slot_free = ~evt_valid_q | evt_ready;

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  assign tick = enable & (pre_q == PreMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (enable) begin
      pre_q <= (pre_q == PreMax) ? '0 : pre_q + PreW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (tick) state_d = StEval;
      end
      StEval: begin
        if (cur_sync == cur_clean || cur_cnt < CntLast) begin
          state_d = StIdle;
        end else if (slot_free) begin
          state_d = StIdle;
        end else begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (xfer) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    commit    = 1'b0;
    cnt_we    = 1'b0;
    cnt_wdata = '0;
    ptr_adv   = 1'b0;
    unique case (state_q)
      StIdle: ;
      StEval: begin
        if (cur_sync == cur_clean) begin
          // Agreeing sample: any partial run is discarded.
          cnt_we  = 1'b1;
          ptr_adv = 1'b1;
        end else if (cur_cnt < CntLast) begin
          cnt_we    = 1'b1;
          cnt_wdata = cur_cnt + CntW'(1);
          ptr_adv   = 1'b1;
        end else if (slot_free) begin
          commit = 1'b1;
        end
      end
      StHold: begin
        if (xfer) commit = 1'b1;
      end
      default: ;
    endcase
    if (commit) begin
      cnt_we    = 1'b1;
      cnt_wdata = '0;
      ptr_adv   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel state and pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= '0;
      end
      clean_q <= '0;
      ptr_q   <= '0;
    end else begin
      if (cnt_we) cnt_q[ptr_q] <= cnt_wdata;
      // A flip always inverts the stored level, so HOLD needs no sample latch.
      if (commit) clean_q[ptr_q] <= ~cur_clean;
      if (ptr_adv) ptr_q <= (ptr_q == PtrLast) ? '0 : ptr_q + PtrW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Event slot and sticky status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_level_q <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      if (commit) begin
        evt_valid_q <= 1'b1;
        evt_ch_q    <= ptr_q;
        evt_level_q <= ~cur_clean;
      end else if (xfer) begin
        evt_valid_q <= 1'b0;
      end
      if (tick && state_q != StIdle) missed_q <= 1'b1;
    end
  end

  assign clean_out   = clean_q;
  assign evt_valid   = evt_valid_q;
  assign evt_ch      = evt_ch_q;
  assign evt_level   = evt_level_q;
  assign missed_tick = missed_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Self-checking bench for debounce_scan_ctrl (N_CH=4, TICK_DIV=4, STABLE_CNT=3).
// A behavioural model is stepped on every rising edge and compared against the
// DUT on every falling edge; directed scenarios add literal expectations at
// fixed edge numbers counted from reset release.
module tb_debounce_scan_ctrl;

  localparam int NCH = 4;
  localparam int TD  = 4;
  localparam int SC  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b1;
  logic [NCH-1:0] raw_in = '0;
  logic [NCH-1:0] clean_out;
  logic           evt_valid;
  logic           evt_ready = 1'b1;
  logic [1:0]     evt_ch;
  logic           evt_level;
  logic           missed_tick;

  int n_chk  = 0;
  int n_fail = 0;
  int e      = 0;

  always #5 clk = ~clk;

  debounce_scan_ctrl #(
    .N_CH      (NCH),
    .TICK_DIV  (TD),
    .STABLE_CNT(SC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ch     (evt_ch),
    .evt_level  (evt_level),
    .missed_tick(missed_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int             m_pc;
  int             m_ptr;
  int             m_cnt [NCH];
  bit             m_clean [NCH];
  bit             m_eval, m_hold, m_valid, m_lvl, m_missed;
  int             m_ch;
  logic [NCH-1:0] m_h0, m_h1;  // raw_in at the previous edge and the one before

  function automatic logic [NCH-1:0] mvec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_clean[i];
    return v;
  endfunction

  task automatic model_step();
    bit tick, xfer, commit, busy, s;
    if (!rst_n) begin
      m_pc = 0; m_ptr = 0; m_eval = 0; m_hold = 0; m_valid = 0; m_lvl = 0;
      m_missed = 0; m_ch = 0; m_h0 = '0; m_h1 = '0;
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0;
        m_clean[i] = 0;
      end
      return;
    end
    tick   = enable && (m_pc == TD - 1);
    xfer   = m_valid && evt_ready;
    commit = 0;
    busy   = m_eval || m_hold;
    if (m_eval) begin
      s = m_h1[m_ptr];
      if (s == m_clean[m_ptr]) begin
        m_cnt[m_ptr] = 0;
        m_ptr = (m_ptr + 1) % NCH;
      end else if (m_cnt[m_ptr] + 1 < SC) begin
        m_cnt[m_ptr]++;
        m_ptr = (m_ptr + 1) % NCH;
      end else if (!m_valid || evt_ready) begin
        commit = 1;
      end else begin
        m_hold = 1;
      end
    end else if (m_hold && xfer) begin
      commit = 1;
    end
    if (commit) begin
      m_clean[m_ptr] = !m_clean[m_ptr];
      m_cnt[m_ptr] = 0;
      m_ch  = m_ptr;
      m_lvl = m_clean[m_ptr];
      m_ptr = (m_ptr + 1) % NCH;
      m_hold = 0;
    end
    if (tick && busy) m_missed = 1;
    m_eval = tick && !busy;
    if (commit) m_valid = 1;
    else if (xfer) m_valid = 0;
    if (enable) m_pc = (m_pc + 1) % TD;
    m_h1 = m_h0;
    m_h0 = raw_in;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare process: every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_clean", 32'(clean_out), 32'(0));
      check("rst_valid", 32'(evt_valid), 32'(0));
      check("rst_missed", 32'(missed_tick), 32'(0));
    end else begin
      check("model_clean", 32'(clean_out), 32'(mvec()));
      check("model_valid", 32'(evt_valid), 32'(m_valid));
      check("model_ch", 32'(evt_ch), 32'(m_ch));
      check("model_level", 32'(evt_level), 32'(m_lvl));
      check("model_missed", 32'(missed_tick), 32'(m_missed));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance to 1 time unit after edge k (edges counted from reset release).
  task automatic goto_edge(input int k);
    step(k - e);
    e = k;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    raw_in = '0;
    evt_ready = 1'b1;
    step(3);
    rst_n = 1'b1;
    e = 0;
  endtask

  task automatic chk_evt(input string name, input logic v, input int ch, input logic lvl,
                         input logic [NCH-1:0] cl);
    check({name, "_valid"}, 32'(evt_valid), 32'(v));
    if (v) begin
      check({name, "_ch"}, 32'(evt_ch), 32'(ch));
      check({name, "_level"}, 32'(evt_level), 32'(lvl));
    end
    check({name, "_clean"}, 32'(clean_out), 32'(cl));
  endtask

  initial begin
    step(2);

    // Quiet inputs after reset: nothing happens.
    do_reset();
    goto_edge(200);
    chk_evt("quiet", 1'b0, 0, 1'b0, 4'b0000);
    check("quiet_missed", 32'(missed_tick), 32'(0));

    // Single clean flip on ch2: visits at edges 13, 29, 45.
    do_reset();
    raw_in = 4'b0100;
    goto_edge(44);
    chk_evt("flip_pre", 1'b0, 0, 1'b0, 4'b0000);
    goto_edge(45);
    chk_evt("flip", 1'b1, 2, 1'b1, 4'b0100);
    goto_edge(46);
    chk_evt("flip_post", 1'b0, 0, 1'b0, 4'b0100);

    // Glitch rejection on ch1: visits at 9, 25, 41(low), 57, 73, 89.
    do_reset();
    raw_in = 4'b0010;
    goto_edge(30);
    raw_in = 4'b0000;
    goto_edge(45);
    raw_in = 4'b0010;
    goto_edge(85);
    chk_evt("glitch_none", 1'b0, 0, 1'b0, 4'b0000);
    goto_edge(89);
    chk_evt("glitch_flip", 1'b1, 1, 1'b1, 4'b0010);

    // Backpressure: ch0 flips at 37, ch3 due at 49 and held, tick at 52 missed.
    do_reset();
    evt_ready = 1'b0;
    raw_in = 4'b1001;
    goto_edge(37);
    chk_evt("bp_first", 1'b1, 0, 1'b1, 4'b0001);
    goto_edge(50);
    chk_evt("bp_hold", 1'b1, 0, 1'b1, 4'b0001);
    check("bp_missed_pre", 32'(missed_tick), 32'(0));
    goto_edge(53);
    check("bp_missed", 32'(missed_tick), 32'(1));
    chk_evt("bp_stable", 1'b1, 0, 1'b1, 4'b0001);
    goto_edge(60);
    evt_ready = 1'b1;
    goto_edge(61);
    chk_evt("bp_b2b", 1'b1, 3, 1'b1, 4'b1001);
    goto_edge(62);
    chk_evt("bp_drain", 1'b0, 0, 1'b0, 4'b1001);

    // Asynchronous reset while in HOLD.
    do_reset();
    evt_ready = 1'b0;
    raw_in = 4'b1001;
    goto_edge(55);
    rst_n = 1'b0;
    #1;
    check("areset_valid", 32'(evt_valid), 32'(0));
    check("areset_clean", 32'(clean_out), 32'(0));
    check("areset_missed", 32'(missed_tick), 32'(0));
    check("areset_ch", 32'(evt_ch), 32'(0));
    check("areset_level", 32'(evt_level), 32'(0));

    // Wrap order and freeze.
    do_reset();
    raw_in = 4'b1111;
    goto_edge(37);
    chk_evt("wrap0", 1'b1, 0, 1'b1, 4'b0001);
    goto_edge(41);
    chk_evt("wrap1", 1'b1, 1, 1'b1, 4'b0011);
    goto_edge(45);
    chk_evt("wrap2", 1'b1, 2, 1'b1, 4'b0111);
    goto_edge(49);
    chk_evt("wrap3", 1'b1, 3, 1'b1, 4'b1111);
    goto_edge(50);
    raw_in = 4'b0000;
    goto_edge(58);
    enable = 1'b0;
    goto_edge(108);
    chk_evt("frozen", 1'b0, 0, 1'b0, 4'b1111);
    enable = 1'b1;
    goto_edge(134);
    chk_evt("resume_pre", 1'b0, 0, 1'b0, 4'b1111);
    goto_edge(135);
    chk_evt("resume0", 1'b1, 0, 1'b0, 4'b1110);
    goto_edge(139);
    chk_evt("resume1", 1'b1, 1, 1'b0, 4'b1100);
    goto_edge(143);
    chk_evt("resume2", 1'b1, 2, 1'b0, 4'b1000);

    // Randomized run against the model.
    do_reset();
    for (int seg = 0; seg < 10; seg++) begin
      int rate, rdy_pct;
      rate    = ($urandom_range(0, 1) == 0) ? 5 : 30;
      rdy_pct = ($urandom_range(0, 2) == 0) ? 10 : 75;
      for (int i = 0; i < 400; i++) begin
        for (int b = 0; b < NCH; b++) begin
          if ($urandom_range(0, 999) < rate) raw_in[b] = ~raw_in[b];
        end
        evt_ready = ($urandom_range(0, 99) < rdy_pct);
        if ($urandom_range(0, 99) < 2) enable = ~enable;
        if (!enable && $urandom_range(0, 99) < 5) enable = 1'b1;
        step(1);
      end
      if (seg == 5) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
